// File: rtl/pll_drp_reconfig_pkg.sv
// rtl/pll_drp_reconfig_pkg.sv - shared states, PLLE4 DRP addresses and RMW helper
package pll_drp_reconfig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_HOLD,
    ST_LOCK_WAIT,
    ST_FINISH
  } state_t;

  localparam logic [6:0] CLKOUT0_REG1  = 7'h08;
  localparam logic [6:0] CLKOUT1_REG1  = 7'h0A;
  localparam logic [6:0] CLKFBOUT_REG1 = 7'h14;

  // Wide enough for a LOCK_TIMEOUT of 65535 with headroom.
  localparam int CNT_W = 17;

  // mask bit 1 keeps the bit read back from the PLL, 0 takes the new value.
  function automatic logic [15:0] rmw_merge(input logic [15:0] old_val,
                                            input logic [15:0] new_val,
                                            input logic [15:0] keep_mask);
    return (old_val & keep_mask) | (new_val & ~keep_mask);
  endfunction

endpackage

// File: rtl/pll_drp_reconfig_sync_bit.sv
// rtl/pll_drp_reconfig_sync_bit.sv - two-flop synchroniser for a single level signal
module pll_drp_reconfig_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_drp_reconfig.sv
// rtl/pll_drp_reconfig.sv - DRP read-modify-write initiator holding the PLL in reset per batch
module pll_drp_reconfig
  import pll_drp_reconfig_pkg::*;
#(
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_data,
  input  logic [15:0] req_mask,
  input  logic        req_last,
  output logic [6:0]  drp_addr,
  output logic [15:0] drp_di,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t            state, state_nx;
  logic [6:0]        addr_q;
  logic [15:0]       data_q, mask_q, rd_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              locked_s;
  logic              drdy_to, lock_to, take;

  pll_drp_reconfig_sync_bit u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  assign drdy_to = (cnt_q == CNT_W'(DRDY_TIMEOUT - 1));
  assign lock_to = (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
  assign take    = req_valid && rst && (state == ST_IDLE || state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    drp_den   = 1'b0;
    drp_dwe   = 1'b0;
    drp_addr  = '0;
    drp_di    = '0;
    done      = 1'b0;
    busy      = (state != ST_IDLE) && (state != ST_FINISH);
    case (state)
      ST_IDLE, ST_HOLD: begin
        req_ready = rst;
        if (take) state_nx = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        drp_den  = 1'b1;
        drp_addr = addr_q;
        state_nx = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (drp_drdy)     state_nx = ST_WR_REQ;
        else if (drdy_to) state_nx = ST_FINISH;
      end
      ST_WR_REQ: begin
        drp_den  = 1'b1;
        drp_dwe  = 1'b1;
        drp_addr = addr_q;
        drp_di   = rmw_merge(rd_q, data_q, mask_q);
        state_nx = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (drp_drdy)     state_nx = last_q ? ST_LOCK_WAIT : ST_HOLD;
        else if (drdy_to) state_nx = ST_FINISH;
      end
      ST_LOCK_WAIT: begin
        if (locked_s || lock_to) state_nx = ST_FINISH;
      end
      ST_FINISH: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath, timeout counter and the PLL reset / error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      rd_q    <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      pll_rst <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (take) begin
            addr_q  <= req_addr;
            data_q  <= req_data;
            mask_q  <= req_mask;
            last_q  <= req_last;
            pll_rst <= 1'b1;
            if (state == ST_IDLE) err <= 1'b0;
          end
        end
        ST_RD_REQ, ST_WR_REQ: cnt_q <= '0;
        ST_RD_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (drp_drdy) begin
            rd_q <= drp_do;
          end else if (drdy_to) begin
            err     <= 1'b1;
            pll_rst <= 1'b0;
          end
        end
        ST_WR_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (drp_drdy) begin
            if (last_q) begin
              cnt_q   <= '0;
              pll_rst <= 1'b0;
            end
          end else if (drdy_to) begin
            err     <= 1'b1;
            pll_rst <= 1'b0;
          end
        end
        ST_LOCK_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (locked_s)     err <= 1'b0;
          else if (lock_to) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
